// File: rtl/prg_pkg.sv
// Shared types and constants for the pseudorandom generator.
// Tap mask selects bits 31,21,1,0 (polynomial x^32 + x^22 + x^2 + x + 1).
package prg_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } prg_state_e;

   localparam logic [31:0] PRG_TAPS     = 32'h8020_0003;
   // An all-zero LFSR would lock up, so a zero seed is replaced with this.
   localparam logic [31:0] PRG_ZERO_SUB = 32'h0000_0001;

endpackage

// File: rtl/pseudorandom_generator_lfsr_step.sv
// lfsr_step: one combinational shift of a Fibonacci LFSR.
// Feedback is the XOR of the bits selected by TAPS, shifted in at bit 0.
module lfsr_step
   import prg_pkg::*;
#(
   parameter int             W    = 32,
   parameter logic [W-1:0]   TAPS = PRG_TAPS[W-1:0]
) (
   input  logic [W-1:0] lfsr_in,
   output logic [W-1:0] lfsr_out
);

   logic fb;

   // Parity of the tapped bits forms the new LSB.
   always_comb begin
      fb       = ^(lfsr_in & TAPS);
      lfsr_out = {lfsr_in[W-2:0], fb};
   end

endmodule

// File: rtl/pseudorandom_generator.sv
// pseudorandom_generator: 32-bit Fibonacci LFSR returning OUT_W random bits
// per start/done handshake. Each request shifts the LFSR STEPS times
// (STEPS must be >= OUT_W so every output bit is fresh).
// Build option PRG_RESEED_EN: reload the LFSR from in_seed on every accepted
// request instead of only on the first one after reset.
module pseudorandom_generator
   import prg_pkg::*;
#(
   parameter int STATE_W = 32,
   parameter int OUT_W   = 8,
   parameter int STEPS   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [STATE_W-1:0] in_seed,
   output logic [OUT_W-1:0]   value,
   output logic               done
);

`ifdef PRG_RESEED_EN
   localparam bit RESEED_EN = 1'b1;
`else
   localparam bit RESEED_EN = 1'b0;
`endif

   localparam int CNT_W = $clog2(STEPS + 1);

   prg_state_e         state_q, state_d;
   logic [STATE_W-1:0] lfsr_q, lfsr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               seeded_q, seeded_d;
   logic [OUT_W-1:0]   value_q, value_d;

   logic [STATE_W-1:0] lfsr_shift;
   logic [STATE_W-1:0] seed_fixed;

   lfsr_step #(
      .W    (STATE_W),
      .TAPS (PRG_TAPS[STATE_W-1:0])
   ) u_step (
      .lfsr_in  (lfsr_q),
      .lfsr_out (lfsr_shift)
   );

   // Zero seed is substituted so the LFSR can never sit at all-zero.
   always_comb begin
      seed_fixed = (in_seed == '0) ? PRG_ZERO_SUB[STATE_W-1:0] : in_seed;
   end

   // Next-state, datapath and result update for the request FSM.
   always_comb begin
      state_d  = state_q;
      lfsr_d   = lfsr_q;
      cnt_d    = cnt_q;
      seeded_d = seeded_q;
      value_d  = value_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SHIFT;
               cnt_d   = '0;
               if (!seeded_q || RESEED_EN) begin
                  lfsr_d   = seed_fixed;
                  seeded_d = 1'b1;
               end
            end
         end
         SHIFT: begin
            lfsr_d = lfsr_shift;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(STEPS - 1)) begin
               state_d = DONE;
               value_d = lfsr_shift[OUT_W-1:0];
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers; synchronous reset aborts any request in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         lfsr_q   <= '0;
         cnt_q    <= '0;
         seeded_q <= 1'b0;
         value_q  <= '0;
      end else begin
         state_q  <= state_d;
         lfsr_q   <= lfsr_d;
         cnt_q    <= cnt_d;
         seeded_q <= seeded_d;
         value_q  <= value_d;
      end
   end

   // done decodes the state register directly: a single-cycle pulse.
   always_comb begin
      done  = (state_q == DONE);
      value = value_q;
   end

endmodule

// File: tb/tb_pseudorandom_generator.sv
// Directed bench for pseudorandom_generator: two instances sharing clock and
// reset, hand-computed vectors plus a small reference LFSR model.
module tb_pseudorandom_generator;

`ifdef PRG_RESEED_EN
   localparam bit RESEED = 1'b1;
`else
   localparam bit RESEED = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start_a, start_b;
   logic [31:0] seed_a, seed_b;
   logic [7:0]  value_a, value_b;
   logic        done_a, done_b;

   int n_chk = 0;
   int n_err = 0;

   logic [31:0] m_a, m_b;
   bit          m_a_seeded, m_b_seeded;

   always #5 clk = ~clk;

   pseudorandom_generator u_a (
      .clk     (clk),
      .rst     (rst),
      .start   (start_a),
      .in_seed (seed_a),
      .value   (value_a),
      .done    (done_a)
   );

   pseudorandom_generator u_b (
      .clk     (clk),
      .rst     (rst),
      .start   (start_b),
      .in_seed (seed_b),
      .value   (value_b),
      .done    (done_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_fix(input logic [31:0] s);
      return (s == 32'h0) ? 32'h1 : s;
   endfunction

   function automatic logic [31:0] m_run(input logic [31:0] s);
      logic [31:0] r;
      r = s;
      for (int i = 0; i < 8; i++) r = {r[30:0], r[31] ^ r[21] ^ r[1] ^ r[0]};
      return r;
   endfunction

   task automatic model_a_req();
      if (!m_a_seeded || RESEED) m_a = m_fix(seed_a);
      m_a_seeded = 1'b1;
      m_a = m_run(m_a);
   endtask

   task automatic model_b_req();
      if (!m_b_seeded || RESEED) m_b = m_fix(seed_b);
      m_b_seeded = 1'b1;
      m_b = m_run(m_b);
   endtask

   // Counts clock edges until done_a is seen (sampled on the falling edge).
   task automatic wait_done(output int cyc);
      cyc = 0;
      do begin
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end while (!done_a && cyc < 40);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, pulses, first;
      rst = 1'b1; start_a = 1'b0; start_b = 1'b0; seed_a = '0; seed_b = '0;
      m_a = '0; m_b = '0; m_a_seeded = 1'b0; m_b_seeded = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_value", value_a, 32'h0);
      chk("rst_done", done_a, 32'h0);
      chk("rst_lfsr", u_a.lfsr_q, 32'h0);
      rst = 1'b0;

      // First request from seed 1, start held high.
      seed_a = 32'h1; start_a = 1'b1;
      wait_done(cyc);
      chk("lat1", cyc, 9);
      chk("val1", value_a, 32'hB6);
      chk("lfsr1", u_a.lfsr_q, 32'h0000_01B6);
      model_a_req();

      // Second back-to-back request: one IDLE cycle between pulses.
      wait_done(cyc);
      chk("gap", cyc, 10);
      chk("val2", value_a, RESEED ? 32'hB6 : 32'hDB);
      chk("lfsr2", u_a.lfsr_q, RESEED ? 32'h0000_01B6 : 32'h0001_B6DB);
      model_a_req();
      start_a = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("pulse_w", done_a, 32'h0);
      repeat (3) begin @(posedge clk); @(negedge clk); end
      chk("hold_val", value_a, RESEED ? 32'hB6 : 32'hDB);
      chk("hold_done", done_a, 32'h0);

      // Seed change after seeding; start toggled during SHIFT.
      seed_a = 32'hDEAD_BEEF; start_a = 1'b1;
      pulses = 0; first = 0;
      for (int i = 1; i <= 14; i++) begin
         @(posedge clk); @(negedge clk);
         if (done_a) begin
            pulses++;
            if (first == 0) first = i;
         end
         start_a = (i < 8) ? (i % 2 == 1) : 1'b0;
      end
      model_a_req();
      chk("tog_pulses", pulses, 1);
      chk("tog_first", first, 9);
      chk("tog_val", value_a, {24'h0, m_a[7:0]});

      // Reset in the middle of SHIFT: no pulse, value cleared.
      start_a = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_a = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      m_a_seeded = 1'b0;
      chk("mid_rst_val", value_a, 32'h0);
      chk("mid_rst_done", done_a, 32'h0);
      pulses = 0;
      repeat (12) begin
         @(posedge clk); @(negedge clk);
         if (done_a) pulses++;
      end
      chk("mid_rst_pulses", pulses, 0);

      // Zero seed after reset gets substituted.
      seed_a = 32'h0; start_a = 1'b1;
      wait_done(cyc);
      model_a_req();
      chk("zero_lat", cyc, 9);
      chk("zero_val", value_a, 32'hB6);
      chk("zero_lfsr", u_a.lfsr_q, m_a);

      // Long run with start held: never stuck, tracks the model.
      for (int k = 0; k < 100; k++) begin
         wait_done(cyc);
         model_a_req();
         chk("soak_val", value_a, {24'h0, m_a[7:0]});
         chk("soak_nz", (u_a.lfsr_q != 32'h0), 32'h1);
      end
      start_a = 1'b0;
      repeat (2) begin @(posedge clk); @(negedge clk); end

      // Two instances with complementary seeds.
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      m_a_seeded = 1'b0; m_b_seeded = 1'b0;
      seed_a = 32'h1234_5678; seed_b = ~32'h1234_5678;
      start_a = 1'b1; start_b = 1'b1;
      for (int k = 0; k < 2; k++) begin
         wait_done(cyc);
         model_a_req();
         model_b_req();
         chk("dual_done_b", done_b, 32'h1);
         chk("dual_val_a", value_a, {24'h0, m_a[7:0]});
         chk("dual_val_b", value_b, {24'h0, m_b[7:0]});
      end
      start_a = 1'b0; start_b = 1'b0;
      repeat (2) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
